// File: rtl/t05_htree_builder.sv
// t05_htree_builder: turns the two least histogram entries into a Huffman node with four SRAM writes.
module t05_htree_builder #(
    parameter int ADDR_W     = 12,
    parameter int HISTO_BASE = 0,
    parameter int NODE_BASE  = 512,
    parameter int MAX_NODES  = 127
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [3:0]        en_state,
    input  logic [8:0]        least1,
    input  logic [8:0]        least2,
    input  logic [63:0]       sum,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [6:0]        node_count,
    output logic              fin_state,
    output logic              tree_done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, CLR1, CLR2, WSUM, WNODE, DONE} state_t;
    localparam logic [8:0] NONE = 9'd384;
    state_t state, nxt;
    logic [8:0] l1_q, l2_q;
    logic [63:0] s_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0] wr_data;
    // sum slots sit right after the 256 char slots, so the 9-bit index is already the table offset
    always_comb begin
        wr_addr = state == CLR1 ? ADDR_W'(HISTO_BASE) + ADDR_W'(l1_q) :
                  state == CLR2 ? ADDR_W'(HISTO_BASE) + ADDR_W'(l2_q) :
                  state == WSUM ? ADDR_W'(HISTO_BASE) + ADDR_W'(256) + ADDR_W'(node_count) :
                                  ADDR_W'(NODE_BASE) + ADDR_W'(node_count);
        wr_data = state == WSUM  ? s_q :
                  state == WNODE ? {l1_q, l2_q, s_q[45:0]} : 64'd0;
        nxt     = state == CLR1 ? CLR2 :
                  state == CLR2 ? WSUM :
                  state == WSUM ? WNODE : DONE;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            l1_q       <= '0;
            l2_q       <= '0;
            s_q        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            node_count <= '0;
            fin_state  <= 1'b0;
            tree_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en_state == 4'd3) begin
                    l1_q <= least1;
                    l2_q <= least2;
                    s_q  <= sum;
                    if (least1 == NONE || least2 == NONE || node_count == 7'(MAX_NODES)) begin
                        state     <= DONE;
                        fin_state <= 1'b1;
                        tree_done <= least1 != NONE && least2 == NONE;
                        err       <= least1 == NONE || (least2 != NONE && node_count == 7'(MAX_NODES));
                    end else begin
                        state <= CLR1;
                    end
                end
                DONE: if (en_state != 4'd3) begin
                    state     <= IDLE;
                    fin_state <= 1'b0;
                    tree_done <= 1'b0;
                    err       <= 1'b0;
                end
                // each write state spends one cycle with req low, then holds req until acked
                default: if (en_state != 4'd3) begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end else if (!mem_req) begin
                    mem_req   <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end else if (mem_ack) begin
                    mem_req <= 1'b0;
                    state   <= nxt;
                    if (state == WNODE) begin
                        node_count <= node_count + 7'd1;
                        fin_state  <= 1'b1;
                    end
                end
            endcase
            if (en_state == 4'd0) node_count <= '0;
        end
    end
endmodule

// File: doc/t05_htree_builder.md
Name: t05_htree_builder

Overview:
- Huffman tree node builder; the stage directly downstream of the least-value finder.
- Consumes the finder's two least indices (least1, least2) and their sum, and performs four SRAM-table writes:
  - Clears both consumed histogram/sum entries to 0; the finder skips zero entries on its next scan.
  - Writes the new sum into the sum region at 256+node_count.
  - Writes the tree node record into the node table.
- Detects the single-survivor case (tree complete) and reports it upstream to the top-level FSM.

Parameters:
- ADDR_W, 12, word address width of the SRAM port.
- HISTO_BASE, 0, base word address of the 384-entry histogram/sum table (index 0-255 chars, 256-383 sums).
- NODE_BASE, 512, base word address of the 128-entry node table.
- MAX_NODES, 127, maximum internal nodes; the next build attempt after this many raises err.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- en_state  in  4  top-level state; the block runs when en_state==3 and clears its counters when en_state==0.
- least1  in  9  index of smallest entry; bit8=0 char (bits7:0), bit8=1 sum slot; 384 = none.
- least2  in  9  index of second smallest entry, same encoding.
- sum  in  64  least1 value + least2 value.
- mem_ack  in  1  SRAM write accepted this cycle.
- mem_req  out  1  write request.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  64  write data.
- node_count  out  7  internal nodes built so far.
- fin_state  out  1  build step finished.
- tree_done  out  1  tree complete; no node built this step.
- err  out  1  node table overflow or empty histogram (least1==384).

Behaviour:
- Reset (nrst low, async):
  - FSM goes to IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, node_count=0, fin_state=0, tree_done=0, err=0.
- FSM states: IDLE, CLR1, CLR2, WSUM, WNODE, DONE.
- IDLE:
  - When en_state==3, latch least1, least2, sum into l1_q, l2_q, s_q.
  - Next state:
    - least1==384 → DONE with err=1.
    - else least2==384 → DONE with tree_done=1.
    - else node_count==MAX_NODES → DONE with err=1.
    - else → CLR1.
- Slot address mapping for index x: x[8]=0 → HISTO_BASE+x[7:0]; x[8]=1 → HISTO_BASE+256+x[7:0].
- CLR1: mem_addr=slot(l1_q), mem_wdata=0.
- CLR2: mem_addr=slot(l2_q), mem_wdata=0.
- WSUM: mem_addr=HISTO_BASE+256+node_count, mem_wdata=s_q.
- WNODE:
  - mem_addr=NODE_BASE+node_count.
  - mem_wdata = {l1_q[8:0], l2_q[8:0], s_q[45:0]}.
  - On ack, node_count increments.
- Write handshake:
  - mem_req is high in every write state.
  - addr/data are stable for as long as req is high.
  - The state advances on the cycle mem_ack is sampled high.
  - mem_req drops for 1 cycle between writes (registered outputs).
  - Minimum 2 cycles per write; mem_ack held high continuously still yields one write per state.
- DONE:
  - fin_state=1, mem_req=0.
  - tree_done/err stay held while en_state==3.
  - On en_state!=3: return to IDLE and clear fin_state, tree_done, err (node_count kept).
- en_state leaves 3 mid-write: abort to IDLE next cycle, mem_req=0, node_count unchanged.
- en_state==0 in any state: node_count clears to 0.
- mem_ack outside a write state is ignored.
- Sum truncation:
  - The node record stores s_q[45:0].
  - The full 64-bit s_q goes to the sum table.
- least1==least2 (not 384): both clear writes are issued to the same address; this is legal.
- Latency with zero-wait ack:
  - IDLE→DONE is 9 cycles for a normal build.
  - 1 cycle for tree_done/err paths.

Test Plan:
- Reset then en_state=3, least1=0x041, least2=0x042, sum=7, ack same cycle as req → writes: addr 0x041 data 0, addr 0x042 data 0, addr 256 data 7, addr 512 data {0x041,0x042,46'd7}; node_count=1; fin_state=1.
- Second build, least1=0x100, least2=0x061, sum=12 → clears addr 256 and 0x061, writes 12 to addr 257, node record at 513; node_count=2.
- least1=0x101, least2=384 → no mem_req; tree_done=1, fin_state=1, node_count unchanged.
- least1=384 → err=1, no writes; en_state→2 clears err/fin_state.
- mem_ack delayed 3 cycles on CLR2 → addr/data held stable, no skipped or duplicate writes; nrst pulsed low during WSUM → all outputs 0 immediately, node_count=0.
- node_count preset to 127 by 127 builds → next build gives err=1, no writes; en_state=0 → node_count=0.
